bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential converter from a 4-digit packed BCD value to 14-bit binary, using the reverse double-dabble (shift-right / subtract-3) algorithm. It is the inverse of the team's binary-to-BCD debug converter. It sits between decimal-entry sources (switch or keypad digit registers) and the binary servo/SPI setpoint logic. Illegal digits (>9) are detected and flagged instead of being converted.

## Interface
- Parameters: none. Width is fixed at 4 digits in and 14 bits out.
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  conversion request; sampled only in Idle.
- BCDIN  in  16  packed BCD; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- BINOUT  out  14  converted value, 0..9999; holds until the next conversion completes.
- BUSY  out  1  high whenever the state is not Idle.
- DONE  out  1  registered one-cycle pulse marking a conversion result.
- ERR  out  1  registered; set with DONE when the last conversion had an illegal digit.

## Operation
- Internal registers:
  - tmpSR[31:0]: BCD field [31:16], binary field [15:0].
  - shiftCount[4:0].
- States: Idle, Init, Shift, Check, Done.
- Idle:
  - On START=1, load tmpSR <= {BCDIN, 16'h0000}, clear shiftCount, go to Init.
  - Otherwise stay in Idle.
- Init:
  - If any nibble of tmpSR[31:16] is above 9, set an internal error flag and go to Done.
  - Otherwise clear the error flag and go to Shift.
- Shift: tmpSR <= tmpSR >> 1 (logical, zero fill), shiftCount += 1, go to Check.
- Check, when shiftCount != 16:
  - For each BCD nibble tmpSR[31:28], [27:24], [23:20], [19:16] that is >= 8, subtract 3.
  - All four nibbles are evaluated in parallel from pre-update values, using 4-bit arithmetic.
  - Go to Shift.
- Check, when shiftCount == 16: no correction, go to Done.
- Done:
  - If the error flag is clear: BINOUT <= tmpSR[13:0], ERR <= 0.
  - If the error flag is set: BINOUT <= 0, ERR <= 1.
  - DONE <= 1.
  - Clear tmpSR and shiftCount, go to Idle.
- DONE is 0 in every other cycle.
- START while BUSY=1 is ignored, not queued.
- BCDIN is captured only at START acceptance. Later changes to BCDIN do not affect the conversion in progress.
- Reset (any state, including mid-conversion):
  - The conversion is aborted and the state returns to Idle.
  - tmpSR = 0, shiftCount = 0, BINOUT = 0, DONE = 0, ERR = 0, BUSY = 0.
- After a valid conversion, the BCD field is 0 and tmpSR[15:14] = 0. Only tmpSR[13:0] is driven out.

## Timing
Edge k is the edge at which START=1 is sampled in Idle.
- Valid input:
  - Edge k+1: Init.
  - Shift number n executes at edge k+2n; Check number n at edge k+2n+1, for n = 1..16.
  - Edge k+34: Done updates BINOUT.
  - DONE=1 and the new BINOUT are visible during the cycle following edge k+34, which is 34 cycles after START.
- Illegal digit: DONE=1 and ERR=1 are visible during the cycle following edge k+2, which is 2 cycles after START.
- BUSY: rises the cycle after edge k and falls in the same cycle that DONE=1.
- Back-to-back: a START sampled during the DONE cycle is accepted, giving a 35-cycle issue interval.

## Test plan
- Reset, then START with BCDIN=16'h0000 -> DONE pulse 34 cycles later; BINOUT=0; ERR=0; BUSY high for exactly 34 cycles.
- BCDIN=16'h9999 -> BINOUT=14'd9999 (0x270F), ERR=0. BCDIN=16'h0512 -> BINOUT=512. BCDIN=16'h1000 -> BINOUT=1000.
- BCDIN=16'h12A4 -> DONE and ERR=1 two cycles after START; BINOUT=0; BUSY low afterwards.
- Start 16'h0042; pulse START with 16'h0099 and change BCDIN at cycle 10 -> result 42; exactly one DONE pulse; the second START is ignored.
- Assert RST at cycle 15 of a 16'h0777 conversion -> all outputs 0 the next cycle; a subsequent START of 16'h0003 -> BINOUT=3 after 34 cycles.
- Back-to-back START in each DONE cycle across 100 random legal values -> every BINOUT matches its decimal value; interval of 35 cycles.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit packed-BCD to 14-bit binary converter (reverse double-dabble).
// Illegal digits (>9) abort the conversion and are reported through ERR with DONE.
module bcd_to_bin (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] BCDIN,
    output logic [13:0] BINOUT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tmp_sr_q, tmp_sr_d;
    logic [4:0]  shift_cnt_q, shift_cnt_d;
    logic        err_flag_q, err_flag_d;
    logic [13:0] binout_q, binout_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Undo one doubling step: a nibble that reached 8+ after the right shift had 3 added going forward.
    function automatic logic [3:0] sub3(input logic [3:0] nib);
        return (nib >= 4'd8) ? nib - 4'd3 : nib;
    endfunction

    function automatic logic illegal(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

    // NOTE: every _d gets a default before the case so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        tmp_sr_d    = tmp_sr_q;
        shift_cnt_d = shift_cnt_q;
        err_flag_d  = err_flag_q;
        binout_d    = binout_q;
        err_d       = err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    tmp_sr_d    = {BCDIN, 16'h0000};
                    shift_cnt_d = 5'd0;
                    state_d     = S_INIT;
                end
            end
            S_INIT: begin
                if (illegal(tmp_sr_q[31:28]) || illegal(tmp_sr_q[27:24]) ||
                    illegal(tmp_sr_q[23:20]) || illegal(tmp_sr_q[19:16])) begin
                    err_flag_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    err_flag_d = 1'b0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                tmp_sr_d    = tmp_sr_q >> 1;
                shift_cnt_d = shift_cnt_q + 5'd1;
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                if (shift_cnt_q == 5'd16) begin
                    state_d = S_DONE;
                end else begin
                    tmp_sr_d = {sub3(tmp_sr_q[31:28]), sub3(tmp_sr_q[27:24]),
                                sub3(tmp_sr_q[23:20]), sub3(tmp_sr_q[19:16]),
                                tmp_sr_q[15:0]};
                    state_d  = S_SHIFT;
                end
            end
            S_DONE: begin
                binout_d    = err_flag_q ? 14'd0 : tmp_sr_q[13:0];
                err_d       = err_flag_q;
                done_d      = 1'b1;
                tmp_sr_d    = 32'd0;
                shift_cnt_d = 5'd0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            tmp_sr_q    <= 32'd0;
            shift_cnt_q <= 5'd0;
            err_flag_q  <= 1'b0;
            binout_q    <= 14'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmp_sr_q    <= tmp_sr_d;
            shift_cnt_q <= shift_cnt_d;
            err_flag_q  <= err_flag_d;
            binout_q    <= binout_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign BINOUT = binout_q;
    assign DONE   = done_q;
    assign ERR    = err_q;
    assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: stimulus pushes expected results, a monitor pops them on DONE.
module tb_bcd_to_bin;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] BCDIN;
    logic [13:0] BINOUT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int n_checks = 0;
    int n_miscompares = 0;

    logic [14:0] sb[$];   // {err, binout}

    bcd_to_bin dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .BCDIN (BCDIN),
        .BINOUT(BINOUT),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    logic [14:0] e;
                    e = sb.pop_front();
                    check("binout", int'(BINOUT), int'(e[13:0]));
                    check("err", int'(ERR), int'(e[14]));
                end
            end
        end
    end

    // Drive START now; returns just after the accepting edge k with START released.
    task automatic issue(input logic [15:0] bcd, input int exp_bin, input bit exp_err);
        START = 1'b1;
        BCDIN = bcd;
        sb.push_back({exp_err, 14'(exp_bin)});
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Counts cycles from edge k until DONE is seen; optionally disturbs inputs mid-conversion.
    task automatic wait_done(input int exp_lat, input string tag, input bit meddle);
        int lat = 0;
        int busy_cnt = 0;
        bit got = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                got = 1;
                break;
            end
            lat++;
            if (BUSY === 1'b1) busy_cnt++;
            if (meddle) begin
                if (lat == 5) begin START = 1'b1; BCDIN = 16'h0099; end
                if (lat == 6) START = 1'b0;
                if (lat == 10) BCDIN = 16'h1234;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
            check({tag, "_busy_at_done"}, int'(BUSY), 0);
        end
    endtask

    task automatic run(input logic [15:0] bcd, input int exp_bin, input bit exp_err,
                       input int exp_lat, input string tag);
        @(posedge CLK);
        #1;
        issue(bcd, exp_bin, exp_err);
        wait_done(exp_lat, tag, 1'b0);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        BCDIN = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("reset_binout", int'(BINOUT), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_err", int'(ERR), 0);
        check("reset_busy", int'(BUSY), 0);

        run(16'h0000, 0, 1'b0, 34, "zero");
        run(16'h9999, 9999, 1'b0, 34, "max");
        run(16'h0512, 512, 1'b0, 34, "v512");
        run(16'h1000, 1000, 1'b0, 34, "v1000");
        run(16'h0001, 1, 1'b0, 34, "v1");
        run(16'h8080, 8080, 1'b0, 34, "v8080");

        // Second START and BCDIN changes during a conversion must be ignored.
        @(posedge CLK);
        #1;
        issue(16'h0042, 42, 1'b0);
        wait_done(34, "ignore", 1'b1);
        begin
            int extra = 0;
            for (int j = 0; j < 40; j++) begin
                @(negedge CLK);
                if (DONE === 1'b1) extra++;
            end
            check("ignore_extra_done", extra, 0);
        end

        run(16'h12A4, 0, 1'b1, 2, "illegal");
        check("illegal_busy_after", int'(BUSY), 0);
        run(16'hF000, 0, 1'b1, 2, "illegal_msd");

        // Reset mid-conversion aborts it and clears every output.
        @(posedge CLK);
        #1;
        issue(16'h0777, 777, 1'b0);
        repeat (14) @(negedge CLK);
        RST = 1'b1;
        void'(sb.pop_back());
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_binout", int'(BINOUT), 0);
        check("midrst_done", int'(DONE), 0);
        check("midrst_err", int'(ERR), 0);
        check("midrst_busy", int'(BUSY), 0);
        run(16'h0003, 3, 1'b0, 34, "after_rst");

        // Back-to-back: each new START is driven during the DONE cycle of the previous one.
        begin
            int v;
            logic [15:0] b;
            @(posedge CLK);
            #1;
            issue(16'h2024, 2024, 1'b0);
            for (int i = 0; i < 100; i++) begin
                wait_done(34, "b2b", 1'b0);
                v = int'($urandom_range(0, 9999));
                b = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
                issue(b, v, 1'b0);
            end
            wait_done(34, "b2b_last", 1'b0);
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
        $finish;
    end

endmodule
